// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: opcodes, flag bit positions and
// the packed result entry that is handed on to writeback.
package alu_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;

  // Bit positions inside the flag register
  localparam int FLAG_Z    = 0;
  localparam int FLAG_V    = 1;
  localparam int FLAG_N    = 2;
  localparam int NUM_FLAGS = 3;

  localparam int unsigned ALU_W = 4;

  // Entry layout {result, ovfl_m, opcode}; the stage packs its own vector in the same order
  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic             ovfl_m;
    logic [1:0]       opcode;
  } alu_entry_t;

  // Add and sub are the only ops whose overflow, sign and V flag mean anything
  function automatic logic is_arith(input logic [1:0] opcode);
    return ~opcode[1];
  endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. main drives the output; skid catches
// the one beat that arrives while main is stalled, so in_ready is fully registered.
module alu_skid_buf #(
  parameter int unsigned DW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic [DW-1:0] main_q, skid_q;
  logic          main_valid_q, skid_valid_q;
  logic          accept, commit;

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready;
  assign commit    = main_valid_q & out_ready;

  // Move data between input, skid and main; skid only fills when main is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (commit) begin
      if (skid_valid_q) begin
        // in_ready is low here, so no accept can coincide
        main_q       <= skid_q;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        main_q <= in_data;
      end else begin
        main_valid_q <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_q       <= in_data;
        main_valid_q <= 1'b1;
      end else begin
        skid_q       <= in_data;
        skid_valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: masks adder overflow for logic ops, buffers results through
// a skid buffer, updates Z/V/N on commit and counts overflowing accepts.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ERR_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_result,
  input  logic                 in_ovfl,
  input  logic [1:0]           in_opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic                 out_ovfl,
  output logic [1:0]           out_opcode,
  output logic                 flag_z,
  output logic                 flag_v,
  output logic                 flag_n,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned EW = WIDTH + 3;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic                 ovfl_m;
  logic [EW-1:0]        in_entry, out_entry;
  logic                 accept, commit;
  logic [NUM_FLAGS-1:0] flags_q;
  logic [ERR_CNT_W-1:0] err_q;

  // Adder error is meaningless for NAND/XOR and is dropped before buffering
  assign ovfl_m   = in_ovfl & is_arith(in_opcode);
  assign in_entry = {in_result, ovfl_m, in_opcode};

  alu_skid_buf #(
    .DW (EW)
  ) u_skid_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_entry)
  );

  assign out_result = out_entry[EW-1:3];
  assign out_ovfl   = out_entry[2];
  assign out_opcode = out_entry[1:0];
  assign accept     = in_valid & in_ready;
  assign commit     = out_valid & out_ready;

  // Flags follow the entry leaving the stage; logic ops only touch Z
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (commit) begin
      flags_q[FLAG_Z] <= (out_result == '0);
      if (is_arith(out_opcode)) begin
        flags_q[FLAG_N] <= out_result[WIDTH-1];
        flags_q[FLAG_V] <= out_ovfl;
      end
    end
  end

  // Saturating count of overflowing add/sub results taken in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if (accept && ovfl_m && (err_q != ERR_MAX)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign flag_z    = flags_q[FLAG_Z];
  assign flag_v    = flags_q[FLAG_V];
  assign flag_n    = flags_q[FLAG_N];
  assign err_count = err_q;

endmodule
